// File: rtl/data_ram_resp.sv
`default_nettype none
// ============================================================================
// data_ram_resp : MEM-stage data memory responder. A load or store completes
// after 1 + WAIT_CYCLES clocks. Optional macro: MEM_ALIGN_CHECK_EN.
// Revision: 1.0
// ============================================================================
module data_ram_resp #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        mem_ready_o,
    output logic        mem_err_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 7) begin : g_bad_wait_cycles
        $error("data_ram_resp: WAIT_CYCLES must be in 0..7");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state, next_state;
    logic [2:0] cnt, cnt_next;

    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_sel;
    logic [31:0] req_data;

    logic        act_we;
    logic [31:0] act_addr;
    logic [3:0]  act_sel;
    logic [31:0] act_data;
    logic        range_err;
    logic        align_err;
    logic        act_err;
    logic        enter_resp;
    logic [ADDR_WIDTH-1:0] word_idx;

    logic [31:0] mem [0:DEPTH-1];

    // With no wait states the request goes straight from IDLE to RESP, so the
    // response must be built from the live inputs rather than the captured copy.
    always_comb begin
        if (state == S_IDLE) begin
            act_we   = mem_we_i;
            act_addr = mem_addr_i;
            act_sel  = mem_sel_i;
            act_data = mem_data_i;
        end else begin
            act_we   = req_we;
            act_addr = req_addr;
            act_sel  = req_sel;
            act_data = req_data;
        end
    end

    assign word_idx  = act_addr[ADDR_WIDTH+1:2];
    assign range_err = (act_addr >> (ADDR_WIDTH + 2)) != 32'd0;

`ifdef MEM_ALIGN_CHECK_EN
    function automatic logic align_ok(input logic [1:0] ofs, input logic [3:0] sel);
        logic ok;
        ok = 1'b0;
        if (sel == 4'b1111 && ofs == 2'b00)                 ok = 1'b1;
        if (sel == 4'b1100 && ofs == 2'b00)                 ok = 1'b1;
        if (sel == 4'b0011 && ofs == 2'b10)                 ok = 1'b1;
        if (sel == (4'b1000 >> ofs))                        ok = 1'b1;
        return ok;
    endfunction
    assign align_err = !align_ok(act_addr[1:0], act_sel);
`else
    logic unused_ofs;
    assign unused_ofs = &{1'b0, act_addr[1:0]};
    assign align_err  = 1'b0;
`endif

    assign act_err = range_err | align_err;

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        case (state)
            S_IDLE: begin
                if (mem_ce_i) begin
                    cnt_next   = 3'(WAIT_CYCLES);
                    next_state = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                cnt_next = cnt - 3'd1;
                if (cnt <= 3'd1) begin
                    next_state = S_RESP;
                end
            end
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    assign enter_resp = (next_state == S_RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= 3'd0;
            mem_data_o  <= 32'd0;
            mem_ready_o <= 1'b0;
            mem_err_o   <= 1'b0;
        end else begin
            state       <= next_state;
            cnt         <= cnt_next;
            mem_ready_o <= enter_resp;
            mem_err_o   <= enter_resp & act_err;
            mem_data_o  <= (enter_resp && !act_we && !act_err) ? mem[word_idx] : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && mem_ce_i) begin
            req_we   <= mem_we_i;
            req_addr <= mem_addr_i;
            req_sel  <= mem_sel_i;
            req_data <= mem_data_i;
        end
    end

    // Store commits on the edge that opens RESP; an abandoning reset blocks it.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && act_we && !act_err) begin
            for (int l = 0; l < 4; l++) begin
                if (act_sel[l]) begin
                    mem[word_idx][8*l +: 8] <= act_data[8*l +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_ram_resp.sv
`default_nettype none
// tb_data_ram_resp : directed plus randomized checks of data_ram_resp with
// zero and three wait states against a word-array reference model.
module tb_data_ram_resp;

    logic        clk;
    logic        rst   [2];
    logic        ce    [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [3:0]  sel   [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        ready [2];
    logic        err   [2];

    int tests = 0;
    int fails = 0;
    logic [31:0] model [2][1024];

    data_ram_resp #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst[0]), .mem_ce_i(ce[0]), .mem_we_i(we[0]),
        .mem_addr_i(addr[0]), .mem_sel_i(sel[0]), .mem_data_i(wdata[0]),
        .mem_data_o(rdata[0]), .mem_ready_o(ready[0]), .mem_err_o(err[0])
    );

    data_ram_resp #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst[1]), .mem_ce_i(ce[1]), .mem_we_i(we[1]),
        .mem_addr_i(addr[1]), .mem_sel_i(sel[1]), .mem_data_i(wdata[1]),
        .mem_data_o(rdata[1]), .mem_ready_o(ready[1]), .mem_err_o(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Error rule taken straight from the legal-pattern list.
    function automatic bit exp_err(input logic [31:0] a, input logic [3:0] s);
        bit e;
        e = (a[31:12] != 20'd0);
`ifdef MEM_ALIGN_CHECK_EN
        case (a[1:0])
            2'd0:    e = e | !(s == 4'b1111 || s == 4'b1100 || s == 4'b1000);
            2'd1:    e = e | (s != 4'b0100);
            2'd2:    e = e | !(s == 4'b0011 || s == 4'b0010);
            default: e = e | (s != 4'b0001);
        endcase
`endif
        return e;
    endfunction

    // Issue one request at an IDLE negedge; return at the next IDLE negedge.
    task automatic run_req(input int d, input logic w, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] dt,
                           input bit tog, input string tag);
        int k;
        int lat;
        bit e;
        logic [31:0] expd;
        logic [31:0] mask;
        lat  = (d == 0) ? 0 : 3;
        e    = exp_err(a, s);
        expd = (w || e) ? 32'h0 : model[d][a[11:2]];
        ce[d] = 1'b1; we[d] = w; addr[d] = a; sel[d] = s; wdata[d] = dt;
        @(negedge clk);
        ce[d] = 1'b0;
        k = 0;
        while (ready[d] !== 1'b1 && k < 20) begin
            if (tog) begin
                ce[d] = 1'($urandom); we[d] = 1'($urandom); addr[d] = $urandom;
                sel[d] = 4'($urandom); wdata[d] = $urandom;
            end
            @(negedge clk);
            k++;
        end
        ce[d] = 1'b0;
        check({tag, "_latency"}, 32'(k), 32'(lat));
        check({tag, "_data"}, rdata[d], expd);
        check({tag, "_err"}, {31'd0, err[d]}, {31'd0, e});
        if (w && !e) begin
            mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
            model[d][a[11:2]] = (model[d][a[11:2]] & ~mask) | (dt & mask);
        end
        @(negedge clk);
        check({tag, "_pulse_end"}, {31'd0, ready[d]}, 32'd0);
        check({tag, "_idle_data"}, rdata[d], 32'd0);
    endtask

    initial begin
        int seen;
        logic [3:0] rs;
        logic [31:0] ra;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; ce[d] = 1'b0; we[d] = 1'b0;
            addr[d] = 32'd0; sel[d] = 4'd0; wdata[d] = 32'd0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset_ready", {31'd0, ready[d]}, 32'd0);
            check("reset_err", {31'd0, err[d]}, 32'd0);
            check("reset_data", rdata[d], 32'd0);
        end
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);

        for (int d = 0; d < 2; d++)
            for (int wi = 0; wi < 64; wi++)
                run_req(d, 1'b1, 32'(wi) << 2, 4'hF, $urandom, 1'b0, "init");

        run_req(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, "st_10");
        run_req(0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, "ld_10");
        check("ld_10_model", model[0][4], 32'hDEADBEEF);
        run_req(0, 1'b1, 32'h20, 4'hF, 32'h11223344, 1'b0, "st_20");
        run_req(0, 1'b1, 32'h21, 4'b0100, 32'h00AB0000, 1'b0, "st_byte_21");
        run_req(0, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, "ld_20");
        check("ld_20_model", model[0][8], 32'h11AB3344);
        run_req(0, 1'b1, 32'h1000, 4'hF, 32'hCAFEF00D, 1'b0, "st_oor");
        run_req(0, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0, "ld_word0");
        run_req(0, 1'b0, 32'h1000, 4'hF, 32'h0, 1'b0, "ld_oor");
        run_req(0, 1'b0, 32'h42, 4'hF, 32'h0, 1'b0, "ld_misaligned_42");

        run_req(1, 1'b1, 32'h50, 4'hF, 32'h0BADC0DE, 1'b0, "w3_st_50");
        run_req(1, 1'b0, 32'h50, 4'hF, 32'h0, 1'b1, "w3_ld_50_toggle");
        run_req(1, 1'b1, 32'h1000, 4'hF, 32'h12345678, 1'b1, "w3_st_oor");

        // Reset in the middle of a WAIT-state store must drop the store.
        ce[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h30; sel[1] = 4'hF; wdata[1] = 32'h55;
        @(negedge clk);
        ce[1] = 1'b0; rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (ready[1] === 1'b1) seen++;
        end
        check("w3_reset_no_ready", 32'(seen), 32'd0);
        run_req(1, 1'b0, 32'h30, 4'hF, 32'h0, 1'b0, "w3_ld_30_after_reset");

        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 60; n++) begin
                case ($urandom_range(7))
                    0: rs = 4'b1111; 1: rs = 4'b1100; 2: rs = 4'b0011;
                    3: rs = 4'b1000; 4: rs = 4'b0100; 5: rs = 4'b0010;
                    6: rs = 4'b0001; default: rs = 4'($urandom);
                endcase
                ra = {20'd0, 4'd0, 6'($urandom), 2'($urandom)};
                if ($urandom_range(7) == 0) ra[31:12] = 20'($urandom_range(1, 20'hFFFFF));
                run_req(d, 1'($urandom), ra, rs, $urandom, d == 1, "rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_ram_resp.md
Name: data_ram_resp

Overview:
- Data-memory responder for the MEM stage's load/store request interface.
- Receives chip-enable, write-enable, address, byte-select and store data from the MEM stage.
- Returns load data plus a one-cycle ready pulse after a configurable wait-state latency, so the pipeline can stall on memory.
- Byte-lane writes are MIPS big-endian; out-of-range accesses are flagged, not executed.

Parameters:
- ADDR_WIDTH, 10, log2 of word depth (1024 x 32-bit words); word index = mem_addr_i[ADDR_WIDTH+1:2].
- WAIT_CYCLES, 0, extra wait states, legal 0..7; request-to-ready latency = 1 + WAIT_CYCLES clocks.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset; synchronous, active-high (1 = RstEnable).
- mem_ce_i  input  1  request valid (ChipEnable = 1).
- mem_we_i  input  1  1 = store, 0 = load.
- mem_addr_i  input  32  byte address.
- mem_sel_i  input  4  byte lanes; sel[3] = bits 31:24 = byte offset 0.
- mem_data_i  input  32  store data.
- mem_data_o  output  32  load data; valid only while mem_ready_o = 1.
- mem_ready_o  output  1  one-cycle completion pulse.
- mem_err_o  output  1  error flag; valid with mem_ready_o.

Behaviour:
- Reset (rst = 1 at a clock edge):
  - FSM goes to IDLE; mem_data_o = 0, mem_ready_o = 0, mem_err_o = 0; wait counter = 0.
  - Memory array is not cleared.
  - Reset mid-transaction abandons it; a pending store is not committed.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If mem_ce_i = 1, capture addr/we/sel/data into request registers.
  - Load wait counter with WAIT_CYCLES.
  - Next state: WAIT if WAIT_CYCLES > 0, else RESP.
- WAIT:
  - Decrement counter each cycle; go to RESP when counter reaches 1.
  - Changes on mem_ce_i and the other inputs are ignored; only captured values are used.
- RESP (outputs registered, asserted for exactly one cycle):
  - mem_ready_o = 1.
  - Store: array word updated only on lanes whose captured sel bit = 1; other lanes unchanged; mem_data_o = 0.
  - Load: mem_data_o = full 32-bit word, independent of sel (the MEM stage extracts bytes).
  - Next state: IDLE.
- Latency and throughput:
  - ce sampled at edge N gives ready high during cycle N+1+WAIT_CYCLES.
  - Minimum spacing between accepted requests is 2 + WAIT_CYCLES cycles (IDLE bubble).
  - The requester drops mem_ce_i in the cycle ready is seen. If mem_ce_i is still 1 in the following IDLE cycle, it is accepted as a new request.
- Out-of-range:
  - Condition: captured addr[31:ADDR_WIDTH+2] != 0.
  - Response: mem_err_o = 1 with ready, store suppressed, mem_data_o = 0.
- Outside RESP: mem_ready_o = 0, mem_err_o = 0, mem_data_o = 0.
- Load-after-store to the same word returns the updated value, because the store commits in its RESP cycle before the next request is captured.
- Read-modify-write of partial lanes is done within RESP; no read/write collision is possible.
- WAIT_CYCLES outside 0..7 is illegal; the implementation checks it at elaboration (error in simulation).

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: legal access patterns are
  - sel = 1111 with addr[1:0] = 00;
  - sel = 1100 or 0011 with addr[0] = 0, and the lane matching addr[1];
  - single-bit sel matching addr[1:0] (00 -> 1000, 01 -> 0100, 10 -> 0010, 11 -> 0001).
- Defined, any other pattern (including sel = 0000): mem_err_o = 1 with ready, store suppressed, load data = 0.
- Not defined: addr[1:0] ignored, sel applied as given, only the range check raises mem_err_o.

Test Plan:
- WAIT_CYCLES=0: store addr 0x10, sel 1111, data 0xDEADBEEF, then load 0x10 -> each ready 1 cycle after capture; load returns 0xDEADBEEF, err 0.
- Byte store over 0x11223344 at 0x20: addr 0x21, sel 0100, data 0x00AB0000 -> load 0x20 returns 0x11AB3344.
- WAIT_CYCLES=3: load request at edge N -> ready high only in cycle N+4; toggling mem_ce_i/addr during WAIT does not change returned data.
- ADDR_WIDTH=10: store to 0x00001000 -> ready with err 1; subsequent load of word 0 unchanged; load of 0x00001000 returns 0, err 1.
- rst=1 during WAIT of a store to 0x30 (data 0x55) -> no ready pulse; word 0x30 keeps its old value; next request serviced normally.
- MEM_ALIGN_CHECK_EN defined: load addr 0x42, sel 1111 -> err 1, data 0. Same stimulus undefined -> err 0, word 0x40 returned.
